// File: rtl/spi_byte_receiver_if.sv
// rtl/spi_byte_receiver_if.sv - SPI pin bundle between an SPI master and the byte receiver
interface spi_byte_receiver_if;
  logic sck;
  logic cs_n;
  logic mosi;
  logic miso;

  modport master (output sck, output cs_n, output mosi, input miso);
  modport slave  (input sck, input cs_n, input mosi, output miso);
endinterface

// File: rtl/spi_byte_receiver.sv
// rtl/spi_byte_receiver.sv - SPI mode 0 slave byte deserialiser with stretched rdy strobe
// Optional MISO echo of the previous byte: define SPI_MISO_ECHO_EN.
module spi_byte_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int RDY_HOLD    = 4
) (
  input  logic                clk,
  input  logic                reset,
  spi_byte_receiver_if.slave  spi,
  output logic [7:0]          rx_byte,
  output logic                rdy,
  output logic                frame_active,
  output logic                overrun
);

  localparam int HW = $clog2(RDY_HOLD + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_d;
  logic                   cs_d;
  logic [7:0]             shift;
  logic [2:0]             bit_cnt;
  logic [HW-1:0]          hold_cnt;

  logic       sck_s, cs_n_s, mosi_s;
  logic       sck_rise, cs_fall, cs_rise;
  logic       accept_rise, complete;
  logic [7:0] new_byte;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_n_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign cs_fall  = ~cs_n_s & cs_d;
  assign cs_rise  = cs_n_s & ~cs_d;
  assign new_byte = {shift[6:0], mosi_s};

  // cs_n_s must be low in the very cycle of the edge; a simultaneous deselect wins.
  assign accept_rise = sck_rise & ~cs_n_s & (state == SHIFT);
  assign complete    = accept_rise & (bit_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      sck_sync     <= '0;
      cs_sync      <= '1;
      mosi_sync    <= '0;
      sck_d        <= 1'b0;
      cs_d         <= 1'b1;
      shift        <= 8'h00;
      bit_cnt      <= 3'd0;
      hold_cnt     <= '0;
      rx_byte      <= 8'h00;
      rdy          <= 1'b0;
      frame_active <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi.sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
      sck_d     <= sck_s;
      cs_d      <= cs_n_s;

      if (rdy) begin
        if (hold_cnt == HW'(1)) rdy <= 1'b0;
        else                    hold_cnt <= hold_cnt - HW'(1);
      end

      if (cs_fall) begin
        state        <= SHIFT;
        frame_active <= 1'b1;
        bit_cnt      <= 3'd0;
        shift        <= 8'h00;
        overrun      <= 1'b0;
      end else if (cs_rise) begin
        state        <= IDLE;
        frame_active <= 1'b0;
        bit_cnt      <= 3'd0;
        shift        <= 8'h00;
      end else if (accept_rise) begin
        shift   <= new_byte;
        bit_cnt <= bit_cnt + 3'd1;
        // A byte landing while the previous one is still being presented is dropped.
        if (complete) begin
          if (rdy) begin
            overrun <= 1'b1;
          end else begin
            rx_byte  <= new_byte;
            rdy      <= 1'b1;
            hold_cnt <= HW'(RDY_HOLD);
          end
        end
      end
    end
  end

`ifdef SPI_MISO_ECHO_EN
  logic [7:0] tx;
  logic       miso_r;
  logic       sck_fall, accept_fall;

  assign sck_fall = ~sck_s & sck_d;
  // The fall right after the 8th rise is the byte boundary, so the freshly loaded MSB must survive it.
  assign accept_fall = sck_fall & ~cs_n_s & (state == SHIFT) & (bit_cnt != 3'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx     <= 8'h00;
      miso_r <= 1'b0;
    end else begin
      if (cs_fall)          tx <= rx_byte;
      else if (complete)    tx <= rdy ? rx_byte : new_byte;
      else if (accept_fall) tx <= {tx[6:0], 1'b0};
      miso_r <= tx[7];
    end
  end

  assign spi.miso = miso_r;
`else
  assign spi.miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_byte_receiver.sv
// tb/tb_spi_byte_receiver.sv - directed self-checking bench for spi_byte_receiver
module tb_spi_byte_receiver;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  spi_byte_receiver_if a_if ();
  spi_byte_receiver_if b_if ();

  logic [7:0] a_rx, b_rx;
  logic       a_rdy, b_rdy, a_fa, b_fa, a_ovr, b_ovr;

  spi_byte_receiver #(.SYNC_STAGES(2), .RDY_HOLD(4)) dut_a (
    .clk(clk), .reset(reset), .spi(a_if.slave),
    .rx_byte(a_rx), .rdy(a_rdy), .frame_active(a_fa), .overrun(a_ovr)
  );

  spi_byte_receiver #(.SYNC_STAGES(2), .RDY_HOLD(40)) dut_b (
    .clk(clk), .reset(reset), .spi(b_if.slave),
    .rx_byte(b_rx), .rdy(b_rdy), .frame_active(b_fa), .overrun(b_ovr)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] a_bytes[$];
  int         a_widths[$];
  logic [7:0] b_bytes[$];
  int         a_run = 0;
  int         a_unstable = 0;
  int         a_miso_bad = 0;
  int         fa_drops = 0;
  logic       a_rdy_q = 1'b0, b_rdy_q = 1'b0;
  logic [7:0] a_rx_q = 8'h00;

  always @(negedge clk) begin
    if (a_rdy && !a_rdy_q) a_bytes.push_back(a_rx);
    if (a_rdy && a_rdy_q && a_rx !== a_rx_q) a_unstable++;
    if (a_rdy) a_run++;
    if (!a_rdy && a_rdy_q) begin
      a_widths.push_back(a_run);
      a_run = 0;
    end
    if (b_rdy && !b_rdy_q) b_bytes.push_back(b_rx);
    if (a_if.miso !== 1'b0) a_miso_bad++;
    a_rdy_q = a_rdy;
    b_rdy_q = b_rdy;
    a_rx_q  = a_rx;
  end

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_pins(input int sel, input logic s, input logic c, input logic m);
    if (sel == 0) begin
      a_if.sck = s; a_if.cs_n = c; a_if.mosi = m;
    end else begin
      b_if.sck = s; b_if.cs_n = c; b_if.mosi = m;
    end
  endtask

  task automatic spi_bits(input int sel, input logic [7:0] data, input int nbits, input int half,
                          output int lat, output logic [7:0] cap);
    lat = -1;
    cap = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      set_pins(sel, 1'b0, 1'b0, data[7-i]);
      clk_wait(half);
      cap = {cap[6:0], (sel == 0) ? a_if.miso : b_if.miso};
      set_pins(sel, 1'b1, 1'b0, data[7-i]);
      for (int k = 0; k < half; k++) begin
        clk_wait(1);
        if (i == nbits - 1 && lat < 0 && ((sel == 0) ? a_rdy : b_rdy)) lat = k + 1;
      end
      if (!((sel == 0) ? a_fa : b_fa)) fa_drops++;
    end
    set_pins(sel, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame(input int sel, input logic c);
    set_pins(sel, 1'b0, c, 1'b0);
    clk_wait(10);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    clk_wait(5);
    checks += 5;
    if (a_rx !== 8'h00) begin failures++; $display("FAIL reset_rx_byte got=%h exp=00", a_rx); end
    if (a_rdy !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%b exp=0", a_rdy); end
    if (a_fa !== 1'b0) begin failures++; $display("FAIL reset_frame_active got=%b exp=0", a_fa); end
    if (a_ovr !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", a_ovr); end
    if (a_if.miso !== 1'b0) begin failures++; $display("FAIL reset_miso got=%b exp=0", a_if.miso); end
    reset = 1'b1;
    clk_wait(5);
  endtask

  task automatic test_single_byte;
    int lat;
    logic [7:0] cap;
    a_bytes.delete(); a_widths.delete();
    frame(0, 1'b0);
    checks++;
    if (a_fa !== 1'b1) begin failures++; $display("FAIL single_frame_active got=%b exp=1", a_fa); end
    spi_bits(0, 8'h55, 8, 8, lat, cap);
    clk_wait(20);
    frame(0, 1'b1);
    checks += 5;
    if (a_bytes.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", a_bytes.size()); end
    else if (a_bytes[0] !== 8'h55) begin failures++; $display("FAIL single_byte got=%h exp=55", a_bytes[0]); end
    if (a_widths.size() != 1 || a_widths[0] != 4) begin
      failures++; $display("FAIL single_rdy_width got=%0d exp=4", (a_widths.size() != 0) ? a_widths[0] : -1);
    end
    if (a_ovr !== 1'b0) begin failures++; $display("FAIL single_overrun got=%b exp=0", a_ovr); end
    if (lat < 3 || lat > 5) begin failures++; $display("FAIL single_latency got=%0d exp=3..5", lat); end
    if (a_unstable != 0) begin failures++; $display("FAIL single_stable got=%0d exp=0", a_unstable); end
  endtask

  task automatic test_stream;
    logic [7:0] vec [8] = '{8'h55, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'hAA, 8'h03};
    int lat;
    logic [7:0] cap;
    a_bytes.delete(); a_widths.delete();
    fa_drops = 0;
    frame(0, 1'b0);
    foreach (vec[i]) spi_bits(0, vec[i], 8, 8, lat, cap);
    clk_wait(20);
    checks += 2;
    if (fa_drops != 0) begin failures++; $display("FAIL stream_frame_active drops=%0d exp=0", fa_drops); end
    if (a_bytes.size() != 8) begin failures++; $display("FAIL stream_count got=%0d exp=8", a_bytes.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= a_bytes.size() || a_bytes[i] !== vec[i] || a_widths[i] != 4) begin
        failures++;
        $display("FAIL stream_byte%0d got=%h exp=%h", i, (i < a_bytes.size()) ? a_bytes[i] : 8'hxx, vec[i]);
      end
    end
    frame(0, 1'b1);
  endtask

  task automatic test_partial;
    int lat;
    logic [7:0] cap;
    a_bytes.delete(); a_widths.delete();
    frame(0, 1'b0);
    spi_bits(0, 8'hFF, 5, 8, lat, cap);
    frame(0, 1'b1);
    frame(0, 1'b0);
    spi_bits(0, 8'h81, 8, 8, lat, cap);
    clk_wait(20);
    frame(0, 1'b1);
    checks += 2;
    if (a_bytes.size() != 1) begin failures++; $display("FAIL partial_count got=%0d exp=1", a_bytes.size()); end
    if (a_rx !== 8'h81) begin failures++; $display("FAIL partial_byte got=%h exp=81", a_rx); end
  endtask

  task automatic test_overrun;
    int lat;
    logic [7:0] cap;
    b_bytes.delete();
    frame(1, 1'b0);
    spi_bits(1, 8'h11, 8, 2, lat, cap);
    spi_bits(1, 8'h22, 8, 2, lat, cap);
    clk_wait(5);
    checks += 3;
    if (b_ovr !== 1'b1) begin failures++; $display("FAIL overrun_flag got=%b exp=1", b_ovr); end
    if (b_rx !== 8'h11) begin failures++; $display("FAIL overrun_rx_byte got=%h exp=11", b_rx); end
    if (b_bytes.size() != 1) begin failures++; $display("FAIL overrun_count got=%0d exp=1", b_bytes.size()); end
    clk_wait(50);
    frame(1, 1'b1);
    checks++;
    if (b_ovr !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%b exp=1", b_ovr); end
    frame(1, 1'b0);
    checks++;
    if (b_ovr !== 1'b0) begin failures++; $display("FAIL overrun_clear got=%b exp=0", b_ovr); end
    frame(1, 1'b1);
  endtask

  task automatic test_mid_reset;
    int lat;
    logic [7:0] cap;
    frame(0, 1'b0);
    spi_bits(0, 8'hFF, 6, 8, lat, cap);
    reset = 1'b0;
    clk_wait(4);
    checks += 4;
    if (a_rx !== 8'h00) begin failures++; $display("FAIL midreset_rx_byte got=%h exp=00", a_rx); end
    if (a_rdy !== 1'b0) begin failures++; $display("FAIL midreset_rdy got=%b exp=0", a_rdy); end
    if (a_fa !== 1'b0) begin failures++; $display("FAIL midreset_frame_active got=%b exp=0", a_fa); end
    if (a_ovr !== 1'b0) begin failures++; $display("FAIL midreset_overrun got=%b exp=0", a_ovr); end
    reset = 1'b1;
    a_bytes.delete(); a_widths.delete();
    clk_wait(10);
    spi_bits(0, 8'hC3, 8, 8, lat, cap);
    clk_wait(20);
    frame(0, 1'b1);
    checks += 2;
    if (a_bytes.size() != 1) begin failures++; $display("FAIL midreset_count got=%0d exp=1", a_bytes.size()); end
    if (a_rx !== 8'hC3) begin failures++; $display("FAIL midreset_byte got=%h exp=c3", a_rx); end
  endtask

  task automatic test_miso;
    int lat;
    logic [7:0] cap;
`ifdef SPI_MISO_ECHO_EN
    frame(0, 1'b0);
    spi_bits(0, 8'hA5, 8, 8, lat, cap);
    spi_bits(0, 8'h3C, 8, 8, lat, cap);
    clk_wait(20);
    frame(0, 1'b1);
    checks += 2;
    if (cap !== 8'hA5) begin failures++; $display("FAIL miso_echo got=%h exp=a5", cap); end
    if (a_rx !== 8'h3C) begin failures++; $display("FAIL miso_rx_byte got=%h exp=3c", a_rx); end
`else
    frame(0, 1'b0);
    spi_bits(0, 8'hA5, 8, 8, lat, cap);
    spi_bits(0, 8'h3C, 8, 8, lat, cap);
    clk_wait(20);
    frame(0, 1'b1);
    checks += 2;
    if (cap !== 8'h00) begin failures++; $display("FAIL miso_idle got=%h exp=00", cap); end
    if (a_miso_bad != 0) begin failures++; $display("FAIL miso_constant high_cycles=%0d exp=0", a_miso_bad); end
`endif
  endtask

  initial begin
    set_pins(0, 1'b0, 1'b1, 1'b0);
    set_pins(1, 1'b0, 1'b1, 1'b0);
    test_reset();
    test_single_byte();
    test_stream();
    test_partial();
    test_overrun();
    test_mid_reset();
    test_miso();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
